pipe_hazard_tracker: RTL and testbench

Parametrised hazard and forwarding controller for the Osiris pipeline. It generalises the fixed EX/MEM/WB hazard unit to NUM_STAGES post-decode stages and a configurable load-data-ready stage. It adds an external pipeline hold and a saturating load-use stall counter. Forwarding selects are resolved at decode and registered into the EX stage. The block sits beside the decode stage and drives the stall, flush and forward-select controls of the datapath.

---
 rtl/pipe_hazard_tracker.sv | 98 +++++++++
 tb/tb_pipe_hazard_tracker.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_tracker.sv
// pipe_hazard_tracker: load-use stall, redirect flush and registered forward-select control
// for NUM_STAGES post-decode stages, with external hold and a saturating stall counter.
module pipe_hazard_tracker #(
   parameter int NUM_STAGES = 3,
   parameter int ADDR_WIDTH = 4,
   parameter int LOAD_READY = 3,
   parameter int PERF_WIDTH = 16,
   localparam int FWD_W = $clog2(NUM_STAGES + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_valid_ID,
   input  logic [ADDR_WIDTH-1:0] i_rs1Addr_ID,
   input  logic [ADDR_WIDTH-1:0] i_rs2Addr_ID,
   input  logic                  i_rs1_used_ID,
   input  logic                  i_rs2_used_ID,
   input  logic [ADDR_WIDTH-1:0] i_rd_ID,
   input  logic                  i_reg_write_ID,
   input  logic                  i_load_ID,
   input  logic                  i_pc_src_EX,
   input  logic                  i_hold,
   output logic                  o_stall_IF,
   output logic                  o_stall_ID,
   output logic                  o_flush_ID,
   output logic                  o_flush_EX,
   output logic [FWD_W-1:0]      o_fwd_rs1_EX,
   output logic [FWD_W-1:0]      o_fwd_rs2_EX,
   output logic [PERF_WIDTH-1:0] o_stall_count
);
   // Index 0 is S1 (EX); index NUM_STAGES-1 is the oldest tracked stage.
   logic [NUM_STAGES-1:0] v_q, v_d, wr_q, wr_d, ld_q, ld_d;
   logic [ADDR_WIDTH-1:0] rd_q [NUM_STAGES];
   logic [ADDR_WIDTH-1:0] rd_d [NUM_STAGES];
   logic [FWD_W-1:0]      fwd1_q, fwd1_d, fwd2_q, fwd2_d, sel1, sel2;
   logic [PERF_WIDTH-1:0] cnt_q, cnt_d;
   logic                  late1, late2, lu, enter;

   // Descending scan so the youngest matching stage overwrites older ones;
   // late* marks a load whose data is not yet forwardable from that stage.
   always_comb begin
      sel1  = '0;
      sel2  = '0;
      late1 = 1'b0;
      late2 = 1'b0;
      for (int i = NUM_STAGES - 2; i >= 0; i--) begin
         if (v_q[i] && wr_q[i] && rd_q[i] == i_rs1Addr_ID) begin
            sel1  = FWD_W'(i + 2);
            late1 = ld_q[i] && (i + 2 < LOAD_READY);
         end
         if (v_q[i] && wr_q[i] && rd_q[i] == i_rs2Addr_ID) begin
            sel2  = FWD_W'(i + 2);
            late2 = ld_q[i] && (i + 2 < LOAD_READY);
         end
      end
   end

   assign lu         = i_valid_ID && ((i_rs1_used_ID && late1) || (i_rs2_used_ID && late2));
   assign enter      = i_valid_ID && !i_pc_src_EX && !lu;
   assign o_stall_IF = i_hold || (!i_pc_src_EX && lu);
   assign o_stall_ID = o_stall_IF;
   assign o_flush_ID = !i_hold && i_pc_src_EX;
   assign o_flush_EX = !i_hold && (i_pc_src_EX || lu);

   always_comb begin
      v_d     = i_hold ? v_q  : {v_q[NUM_STAGES-2:0], enter};
      wr_d    = i_hold ? wr_q : {wr_q[NUM_STAGES-2:0], enter && i_reg_write_ID && i_rd_ID != '0};
      ld_d    = i_hold ? ld_q : {ld_q[NUM_STAGES-2:0], enter && i_load_ID};
      rd_d[0] = i_hold ? rd_q[0] : i_rd_ID;
      for (int i = 1; i < NUM_STAGES; i++) rd_d[i] = i_hold ? rd_q[i] : rd_q[i-1];
      fwd1_d  = i_hold ? fwd1_q : (enter ? sel1 : '0);
      fwd2_d  = i_hold ? fwd2_q : (enter ? sel2 : '0);
      cnt_d   = (!i_hold && lu && !i_pc_src_EX && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v_q    <= '0;
         wr_q   <= '0;
         ld_q   <= '0;
         for (int i = 0; i < NUM_STAGES; i++) rd_q[i] <= '0;
         fwd1_q <= '0;
         fwd2_q <= '0;
         cnt_q  <= '0;
      end else begin
         v_q    <= v_d;
         wr_q   <= wr_d;
         ld_q   <= ld_d;
         rd_q   <= rd_d;
         fwd1_q <= fwd1_d;
         fwd2_q <= fwd2_d;
         cnt_q  <= cnt_d;
      end
   end

   assign o_fwd_rs1_EX  = fwd1_q;
   assign o_fwd_rs2_EX  = fwd2_q;
   assign o_stall_count = cnt_q;
endmodule

// File: tb/tb_pipe_hazard_tracker.sv
// tb_pipe_hazard_tracker: directed vectors; expected outputs queued per cycle and
// checked by an independent negedge monitor. Extra instances cover LOAD_READY=2 and counter saturation.
module tb_pipe_hazard_tracker;
   logic       clk = 1'b0, rst = 1'b0;
   logic       v = 0, u1 = 0, u2 = 0, wr = 0, ld = 0, pc = 0, hd = 0;
   logic [3:0] r1 = 0, r2 = 0, rd = 0;
   logic       s_if, s_id, f_id, f_ex, s_if2, s_id2, f_id2, f_ex2, s_if3, s_id3, f_id3, f_ex3;
   logic [1:0] fw1, fw2, fw1_2, fw2_2, fw1_3, fw2_3;
   logic [15:0] cnt, cnt2;
   logic [1:0]  cnt3;

   typedef struct {
      string n;
      int s, fi, fe, f1, f2, c, x, xs, xf, xc;
   } exp_t;
   exp_t sb[$];
   int n_chk = 0, n_fail = 0;
   int x_m = 0, x_s = 0, x_f = 0, x_c = 0;

   always #5 clk = ~clk;

   pipe_hazard_tracker dut (.clk(clk), .rst(rst), .i_valid_ID(v), .i_rs1Addr_ID(r1), .i_rs2Addr_ID(r2),
      .i_rs1_used_ID(u1), .i_rs2_used_ID(u2), .i_rd_ID(rd), .i_reg_write_ID(wr), .i_load_ID(ld),
      .i_pc_src_EX(pc), .i_hold(hd), .o_stall_IF(s_if), .o_stall_ID(s_id), .o_flush_ID(f_id),
      .o_flush_EX(f_ex), .o_fwd_rs1_EX(fw1), .o_fwd_rs2_EX(fw2), .o_stall_count(cnt));

   pipe_hazard_tracker #(.LOAD_READY(2)) dut2 (.clk(clk), .rst(rst), .i_valid_ID(v), .i_rs1Addr_ID(r1),
      .i_rs2Addr_ID(r2), .i_rs1_used_ID(u1), .i_rs2_used_ID(u2), .i_rd_ID(rd), .i_reg_write_ID(wr),
      .i_load_ID(ld), .i_pc_src_EX(pc), .i_hold(hd), .o_stall_IF(s_if2), .o_stall_ID(s_id2),
      .o_flush_ID(f_id2), .o_flush_EX(f_ex2), .o_fwd_rs1_EX(fw1_2), .o_fwd_rs2_EX(fw2_2), .o_stall_count(cnt2));

   pipe_hazard_tracker #(.PERF_WIDTH(2)) dut3 (.clk(clk), .rst(rst), .i_valid_ID(v), .i_rs1Addr_ID(r1),
      .i_rs2Addr_ID(r2), .i_rs1_used_ID(u1), .i_rs2_used_ID(u2), .i_rd_ID(rd), .i_reg_write_ID(wr),
      .i_load_ID(ld), .i_pc_src_EX(pc), .i_hold(hd), .o_stall_IF(s_if3), .o_stall_ID(s_id3),
      .o_flush_ID(f_id3), .o_flush_EX(f_ex3), .o_fwd_rs1_EX(fw1_3), .o_fwd_rs2_EX(fw2_3), .o_stall_count(cnt3));

   task automatic cmp(input string n, input string f, input int act, input int want);
      n_chk++;
      if (act != want) begin
         n_fail++;
         $display("FAIL %s.%s: got %0d expected %0d", n, f, act, want);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         cmp(e.n, "stall_IF", int'(s_if), e.s);
         cmp(e.n, "stall_ID", int'(s_id), e.s);
         cmp(e.n, "flush_ID", int'(f_id), e.fi);
         cmp(e.n, "flush_EX", int'(f_ex), e.fe);
         cmp(e.n, "fwd_rs1", int'(fw1), e.f1);
         cmp(e.n, "fwd_rs2", int'(fw2), e.f2);
         cmp(e.n, "stall_count", int'(cnt), e.c);
         if (e.x == 1) begin
            cmp(e.n, "lr2_stall", int'(s_id2), e.xs);
            cmp(e.n, "lr2_fwd_rs1", int'(fw1_2), e.xf);
            cmp(e.n, "lr2_count", int'(cnt2), e.xc);
         end
         if (e.x == 2) cmp(e.n, "sat_count", int'(cnt3), e.xc);
      end
   end

   task automatic drv(input bit rn, input bit vv, input int a1, input bit uu1, input int a2, input bit uu2,
                      input int d, input bit w, input bit l, input bit p, input bit h);
      rst = rn; v = vv; r1 = 4'(a1); u1 = uu1; r2 = 4'(a2); u2 = uu2;
      rd = 4'(d); wr = w; ld = l; pc = p; hd = h;
   endtask

   task automatic idle();
      drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic xset(input int m, input int s, input int f, input int c);
      x_m = m; x_s = s; x_f = f; x_c = c;
   endtask

   task automatic chk(input string n, input int s, input int fi, input int fe, input int f1, input int f2, input int c);
      exp_t e;
      e.n = n; e.s = s; e.fi = fi; e.fe = fe; e.f1 = f1; e.f2 = f2; e.c = c;
      e.x = x_m; e.xs = x_s; e.xf = x_f; e.xc = x_c;
      x_m = 0;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      @(posedge clk);
      #1;
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); chk("rst0", 0, 0, 0, 0, 0, 0);
      drv(1, 1, 1, 1, 2, 1, 3, 1, 0, 0, 0); chk("alu", 0, 0, 0, 0, 0, 0);
      idle();                               chk("alu_ex", 0, 0, 0, 0, 0, 0);
      drv(1, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0); chk("b2b_p", 0, 0, 0, 0, 0, 0);
      drv(1, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0); chk("b2b_c", 0, 0, 0, 0, 0, 0);
      idle();                               chk("b2b_ex", 0, 0, 0, 2, 0, 0);
      drv(1, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0); chk("d2_p", 0, 0, 0, 0, 0, 0);
      idle();                               chk("d2_nop", 0, 0, 0, 0, 0, 0);
      drv(1, 1, 0, 0, 5, 1, 8, 1, 0, 0, 0); chk("d2_c", 0, 0, 0, 0, 0, 0);
      idle();                               chk("d2_ex", 0, 0, 0, 0, 3, 0);
      drv(1, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0); chk("yw_p1", 0, 0, 0, 0, 0, 0);
      drv(1, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0); chk("yw_p2", 0, 0, 0, 0, 0, 0);
      drv(1, 1, 0, 0, 5, 1, 9, 1, 0, 0, 0); chk("yw_c", 0, 0, 0, 0, 0, 0);
      idle();                               chk("yw_ex", 0, 0, 0, 0, 2, 0);
      drv(1, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0); chk("lu_ld", 0, 0, 0, 0, 0, 0);
      drv(1, 1, 7, 1, 0, 0, 10, 1, 0, 0, 0); xset(1, 0, 0, 0); chk("lu_c", 1, 0, 1, 0, 0, 0);
      drv(1, 1, 7, 1, 0, 0, 10, 1, 0, 0, 0); xset(1, 0, 2, 0); chk("lu_c2", 0, 0, 0, 0, 0, 1);
      idle();                               chk("lu_ex", 0, 0, 0, 3, 0, 1);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); chk("rst_mid", 0, 0, 0, 0, 0, 0);
      idle();                               chk("rst_rel", 0, 0, 0, 0, 0, 0);
      drv(1, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0); chk("rd_ld", 0, 0, 0, 0, 0, 0);
      drv(1, 1, 7, 1, 0, 0, 10, 1, 0, 1, 0); chk("rd_pc", 0, 1, 1, 0, 0, 0);
      drv(1, 1, 7, 1, 10, 1, 11, 1, 0, 0, 0); chk("rd_after", 0, 0, 0, 0, 0, 0);
      idle();                               chk("rd_ex", 0, 0, 0, 3, 0, 0);
      drv(1, 1, 0, 0, 0, 0, 12, 1, 0, 0, 0); chk("h_p", 0, 0, 0, 0, 0, 0);
      drv(1, 1, 12, 1, 0, 0, 13, 1, 0, 0, 0); chk("h_c", 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         drv(1, 1, 13, 1, 0, 0, 14, 1, 0, 1, 1); chk("hold", 1, 0, 0, 2, 0, 0);
      end
      drv(1, 1, 13, 1, 12, 1, 14, 1, 0, 0, 0); chk("h_rel", 0, 0, 0, 2, 0, 0);
      idle();                               chk("h_ex", 0, 0, 0, 2, 3, 0);
      drv(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0); chk("x0_p", 0, 0, 0, 0, 0, 0);
      drv(1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0); chk("x0_c", 0, 0, 0, 0, 0, 0);
      idle();                               chk("x0_ex", 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 5; k++) begin
         drv(1, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0);  xset(2, 0, 0, k < 3 ? k : 3);
         chk("sat_ld", 0, 0, 0, k == 0 ? 0 : 3, 0, k);
         drv(1, 1, 7, 1, 0, 0, 10, 1, 0, 0, 0); xset(2, 0, 0, k < 3 ? k : 3);
         chk("sat_c", 1, 0, 1, 0, 0, k);
         drv(1, 1, 7, 1, 0, 0, 10, 1, 0, 0, 0); xset(2, 0, 0, k + 1 < 3 ? k + 1 : 3);
         chk("sat_c2", 0, 0, 0, 0, 0, k + 1);
      end
      idle();
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      if (sb.size() > 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
